// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-state encoding and BCD score helpers
package game_pkg;

  localparam int BCD_W = 16;
  localparam int BCD_DIGITS = BCD_W / 4;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_RUN  = 2'b01,
    GS_OVER = 2'b10
  } gamestate_t;

  // +1 with per-digit carry; the counter pins at all nines instead of wrapping
  function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    if (v == {BCD_DIGITS{4'h9}}) begin
      return v;
    end
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // digit-wise magnitude compare, most significant digit decides first
  function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      if (a[i*4 +: 4] > b[i*4 +: 4]) return 1'b1;
      if (a[i*4 +: 4] < b[i*4 +: 4]) return 1'b0;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debounce filter and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // level is only accepted after it has disagreed with the current one for the full window
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow FSM with collision latch, lockout and BCD scoring
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LOCKOUT_FRAMES  = 30,
  parameter int SCORE_FRAMES    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_jump,
  input  logic             collision,
  input  logic             frame_tick,
  output logic [1:0]       gamestate,
  output logic             round_reset,
  output logic             jump_pulse,
  output logic [BCD_W-1:0] score,
  output logic [BCD_W-1:0] hiscore
);

  localparam int LW = $clog2(LOCKOUT_FRAMES + 1);
  localparam int FW = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCKOUT_FRAMES);
  localparam logic [FW-1:0] FR_LAST  = FW'(SCORE_FRAMES - 1);

  gamestate_t       state, state_n;
  logic             press;
  logic             coll_flag, coll_n;
  logic [LW-1:0]    lockout, lock_n;
  logic [FW-1:0]    fcnt, fcnt_n;
  logic [BCD_W-1:0] score_n, hi_n;
  logic             rr_n, jp_n;
  logic             hit;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_jump),
    .press(press)
  );

  assign gamestate = state;

  // a frame ends the round if any collision was seen during it, including on the tick itself
  assign hit = frame_tick && (coll_flag || collision);

  // next-state and next-output decode; collision beats a same-cycle jump
  always_comb begin
    state_n = state;
    coll_n  = 1'b0;
    lock_n  = lockout;
    fcnt_n  = fcnt;
    score_n = score;
    hi_n    = hiscore;
    rr_n    = 1'b0;
    jp_n    = 1'b0;
    case (state)
      GS_IDLE: begin
        if (press) begin
          state_n = GS_RUN;
          rr_n    = 1'b1;
          jp_n    = 1'b1;
          score_n = '0;
          fcnt_n  = '0;
        end
      end
      GS_RUN: begin
        if (hit) begin
          state_n = GS_OVER;
          lock_n  = '0;
          if (bcd_gt(score, hiscore)) hi_n = score;
        end else begin
          jp_n = press;
          if (frame_tick) begin
            if (fcnt == FR_LAST) begin
              fcnt_n  = '0;
              score_n = bcd_inc_sat(score);
            end else begin
              fcnt_n = fcnt + 1'b1;
            end
          end else begin
            coll_n = coll_flag || collision;
          end
        end
      end
      GS_OVER: begin
        if (press && lockout == LOCK_MAX) begin
          state_n = GS_RUN;
          rr_n    = 1'b1;
          score_n = '0;
          fcnt_n  = '0;
        end else if (frame_tick && lockout < LOCK_MAX) begin
          lock_n = lockout + 1'b1;
        end
      end
      default: begin
        state_n = GS_IDLE;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GS_IDLE;
      coll_flag   <= 1'b0;
      lockout     <= '0;
      fcnt        <= '0;
      score       <= '0;
      hiscore     <= '0;
      round_reset <= 1'b0;
      jump_pulse  <= 1'b0;
    end else begin
      state       <= state_n;
      coll_flag   <= coll_n;
      lockout     <= lock_n;
      fcnt        <= fcnt_n;
      score       <= score_n;
      hiscore     <= hi_n;
      round_reset <= rr_n;
      jump_pulse  <= jp_n;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

  localparam int D = 4;
  localparam int L = 3;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_jump = 1'b0;
  logic        collision = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  gamestate;
  logic        round_reset;
  logic        jump_pulse;
  logic [15:0] score;
  logic [15:0] hiscore;

  int tests  = 0;
  int failed = 0;

  game_state_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_FRAMES (L),
    .SCORE_FRAMES   (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_jump   (btn_jump),
    .collision  (collision),
    .frame_tick (frame_tick),
    .gamestate  (gamestate),
    .round_reset(round_reset),
    .jump_pulse (jump_pulse),
    .score      (score),
    .hiscore    (hiscore)
  );

  always #5 clk = ~clk;

  // reference model: game as plain integers, button as a history window
  int   ms = 0;
  int   m_score = 0;
  int   m_hi = 0;
  int   m_lock = 0;
  int   m_fc = 0;
  logic m_coll = 1'b0;
  logic m_rr = 1'b0;
  logic m_jp = 1'b0;
  logic m_acc = 1'b0;
  logic m_press = 1'b0;
  logic bq[$];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_edge(input logic b, input logic c, input logic t, input logic r);
    logic p;
    bit   all_diff;
    if (r) begin
      ms = 0; m_score = 0; m_hi = 0; m_lock = 0; m_fc = 0;
      m_coll = 1'b0; m_rr = 1'b0; m_jp = 1'b0; m_acc = 1'b0; m_press = 1'b0;
      bq.delete();
      for (int i = 0; i < D + 2; i++) bq.push_back(1'b0);
      return;
    end
    p = m_press;
    m_rr = 1'b0;
    m_jp = 1'b0;
    if (ms == 0) begin
      if (p) begin
        ms = 1; m_rr = 1'b1; m_jp = 1'b1; m_score = 0; m_fc = 0;
      end
    end else if (ms == 1) begin
      if (t && (m_coll || c)) begin
        ms = 2; m_lock = 0; m_coll = 1'b0;
        if (m_score > m_hi) m_hi = m_score;
      end else begin
        if (p) m_jp = 1'b1;
        if (t) begin
          m_coll = 1'b0;
          m_fc++;
          if (m_fc == S) begin
            m_fc = 0;
            if (m_score < 9999) m_score++;
          end
        end else if (c) begin
          m_coll = 1'b1;
        end
      end
    end else begin
      if (p && m_lock == L) begin
        ms = 1; m_rr = 1'b1; m_score = 0; m_fc = 0;
      end else if (t && m_lock < L) begin
        m_lock++;
      end
    end
    // button accepted when the D samples seen two cycles late all disagree with the held level
    bq.push_back(b);
    if (bq.size() > D + 8) void'(bq.pop_front());
    all_diff = 1'b1;
    for (int i = 2; i < D + 2; i++) begin
      if (bq[bq.size() - 1 - i] == m_acc) all_diff = 1'b0;
    end
    m_press = 1'b0;
    if (all_diff) begin
      m_acc   = ~m_acc;
      m_press = m_acc;
    end
  endtask

  task automatic cyc(input logic b, input logic c, input logic t, input logic r);
    btn_jump   = b;
    collision  = c;
    frame_tick = t;
    rst        = r;
    @(posedge clk);
    model_edge(b, c, t, r);
    #1;
  endtask

  task automatic do_press(output int seen_rr, output int seen_jp, output logic [1:0] st_at,
                          output logic [15:0] sc_at);
    seen_rr = 0;
    seen_jp = 0;
    st_at   = 2'b11;
    sc_at   = 16'hffff;
    for (int i = 0; i < 2 * D + 8; i++) begin
      cyc(i < D + 4, 1'b0, 1'b0, 1'b0);
      if (jump_pulse) seen_jp++;
      if (round_reset) begin
        seen_rr++;
        st_at = gamestate;
        sc_at = score;
      end
    end
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    tests++; if (gamestate !== 2'b00) begin failed++; $display("FAIL reset_state got %0d want 0", gamestate); end
    tests++; if (score !== 16'h0) begin failed++; $display("FAIL reset_score got %h want 0000", score); end
    tests++; if (hiscore !== 16'h0) begin failed++; $display("FAIL reset_hiscore got %h want 0000", hiscore); end
    tests++; if (round_reset !== 1'b0) begin failed++; $display("FAIL reset_rr got %b want 0", round_reset); end
    tests++; if (jump_pulse !== 1'b0) begin failed++; $display("FAIL reset_jp got %b want 0", jump_pulse); end
  endtask

  task automatic test_glitch;
    int njp = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0);
      if (jump_pulse || round_reset) njp++;
    end
    tests++; if (njp != 0) begin failed++; $display("FAIL glitch_pulses got %0d want 0", njp); end
    tests++; if (gamestate !== 2'b00) begin failed++; $display("FAIL glitch_state got %0d want 0", gamestate); end
  endtask

  task automatic test_start;
    int njp = 0, nrr = 0, both = 0, first = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0);
      if (jump_pulse) begin
        njp++;
        if (first < 0) first = i;
        if (round_reset) both++;
      end
      if (round_reset) nrr++;
    end
    tests++; if (njp != 1) begin failed++; $display("FAIL start_jp_count got %0d want 1", njp); end
    tests++; if (nrr != 1) begin failed++; $display("FAIL start_rr_count got %0d want 1", nrr); end
    tests++; if (both != 1) begin failed++; $display("FAIL start_same_cycle got %0d want 1", both); end
    tests++; if (first != D + 2) begin failed++; $display("FAIL start_latency got %0d want %0d", first, D + 2); end
    tests++; if (gamestate !== 2'b01) begin failed++; $display("FAIL start_state got %0d want 1", gamestate); end
    tests++; if (score !== 16'h0) begin failed++; $display("FAIL start_score got %h want 0000", score); end
    for (int i = 0; i < D + 4; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_score;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    tests++; if (score !== 16'h0005) begin failed++; $display("FAIL score_10ticks got %h want 0005", score); end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    tests++; if (gamestate !== 2'b01) begin failed++; $display("FAIL coll_before_tick got %0d want 1", gamestate); end
    cyc(0, 0, 1, 0);
    tests++; if (gamestate !== 2'b10) begin failed++; $display("FAIL coll_over got %0d want 2", gamestate); end
    tests++; if (hiscore !== 16'h0005) begin failed++; $display("FAIL coll_hiscore got %h want 0005", hiscore); end
    tests++; if (score !== 16'h0005) begin failed++; $display("FAIL coll_score_hold got %h want 0005", score); end
  endtask

  task automatic test_lockout;
    int          nrr, njp;
    logic [1:0]  st_at;
    logic [15:0] sc_at;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    do_press(nrr, njp, st_at, sc_at);
    tests++; if (nrr + njp != 0) begin failed++; $display("FAIL lockout_pulses got %0d want 0", nrr + njp); end
    tests++; if (gamestate !== 2'b10) begin failed++; $display("FAIL lockout_state got %0d want 2", gamestate); end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    do_press(nrr, njp, st_at, sc_at);
    tests++; if (nrr != 1) begin failed++; $display("FAIL restart_rr got %0d want 1", nrr); end
    tests++; if (njp != 0) begin failed++; $display("FAIL restart_jp got %0d want 0", njp); end
    tests++; if (st_at !== 2'b01) begin failed++; $display("FAIL restart_state got %0d want 1", st_at); end
    tests++; if (sc_at !== 16'h0) begin failed++; $display("FAIL restart_score got %h want 0000", sc_at); end
  endtask

  task automatic test_second_round;
    int          nrr, njp;
    logic [1:0]  st_at;
    logic [15:0] sc_at;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    tests++; if (score !== 16'h0003) begin failed++; $display("FAIL round2_score got %h want 0003", score); end
    cyc(0, 1, 1, 0);
    tests++; if (gamestate !== 2'b10) begin failed++; $display("FAIL round2_over got %0d want 2", gamestate); end
    tests++; if (hiscore !== 16'h0005) begin failed++; $display("FAIL round2_hiscore got %h want 0005", hiscore); end
    for (int i = 0; i < L; i++) cyc(0, 0, 1, 0);
    do_press(nrr, njp, st_at, sc_at);
    tests++; if (gamestate !== 2'b01) begin failed++; $display("FAIL round3_state got %0d want 1", gamestate); end
    for (int i = 0; i < 9999 * S; i++) cyc(0, 0, 1, 0);
    tests++; if (score !== 16'h9999) begin failed++; $display("FAIL sat_reach got %h want 9999", score); end
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    tests++; if (score !== 16'h9999) begin failed++; $display("FAIL sat_hold got %h want 9999", score); end
    tests++; if (score !== to_bcd(m_score)) begin failed++; $display("FAIL sat_model got %h want %h", score, to_bcd(m_score)); end
  endtask

  task automatic test_press_collision;
    int njp = 0;
    for (int i = 1; i <= D + 6; i++) begin
      cyc(i <= D + 4, i == D + 3, i == D + 3, 1'b0);
      if (jump_pulse) njp++;
      if (i == D + 3) begin
        tests++; if (gamestate !== 2'b10) begin failed++; $display("FAIL presscoll_state got %0d want 2", gamestate); end
      end
    end
    tests++; if (njp != 0) begin failed++; $display("FAIL presscoll_jp got %0d want 0", njp); end
    tests++; if (hiscore !== 16'h9999) begin failed++; $display("FAIL presscoll_hiscore got %h want 9999", hiscore); end
    for (int i = 0; i < D + 4; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_mid_rst;
    int          nrr, njp;
    logic [1:0]  st_at;
    logic [15:0] sc_at;
    for (int i = 0; i < L; i++) cyc(0, 0, 1, 0);
    do_press(nrr, njp, st_at, sc_at);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    tests++; if (score !== 16'h0002) begin failed++; $display("FAIL prerst_score got %h want 0002", score); end
    cyc(0, 0, 0, 1);
    tests++; if (gamestate !== 2'b00) begin failed++; $display("FAIL midrst_state got %0d want 0", gamestate); end
    tests++; if (score !== 16'h0) begin failed++; $display("FAIL midrst_score got %h want 0000", score); end
    tests++; if (hiscore !== 16'h0) begin failed++; $display("FAIL midrst_hiscore got %h want 0000", hiscore); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random;
    int   hold = 0;
    logic b = 1'b0;
    logic prev_rr = 1'b0, prev_jp = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        b    = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 2 * D + 2);
      end
      hold--;
      cyc(b, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 799) == 0);
      tests++; if (gamestate !== 2'(ms)) begin failed++; $display("FAIL rand_state n=%0d got %0d want %0d", n, gamestate, ms); end
      tests++; if (round_reset !== m_rr) begin failed++; $display("FAIL rand_rr n=%0d got %b want %b", n, round_reset, m_rr); end
      tests++; if (jump_pulse !== m_jp) begin failed++; $display("FAIL rand_jp n=%0d got %b want %b", n, jump_pulse, m_jp); end
      tests++; if (score !== to_bcd(m_score)) begin failed++; $display("FAIL rand_score n=%0d got %h want %h", n, score, to_bcd(m_score)); end
      tests++; if (hiscore !== to_bcd(m_hi)) begin failed++; $display("FAIL rand_hiscore n=%0d got %h want %h", n, hiscore, to_bcd(m_hi)); end
      tests++; if ((prev_rr && round_reset) || (prev_jp && jump_pulse)) begin
        failed++; $display("FAIL rand_double_pulse n=%0d got rr=%b jp=%b want no repeat", n, round_reset, jump_pulse);
      end
      prev_rr = round_reset;
      prev_jp = jump_pulse;
    end
  endtask

  initial begin
    for (int i = 0; i < D + 2; i++) bq.push_back(1'b0);
    test_reset();
    test_glitch();
    test_start();
    test_score();
    test_lockout();
    test_second_round();
    test_press_collision();
    test_mid_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
